// File: rtl/garbage_sender.sv
// garbage_sender: converts line-clear events into queued attack lines emitted as one-hot hole masks.
// Define GARBAGE_BACK_TO_BACK_EN to enable the back-to-back (+1) attack bonus.
module garbage_sender #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned MAX_ATTACK = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rng,
    input  logic        clear_valid,
    input  logic [2:0]  clear_lines,
    input  logic [7:0]  clear_combo,
    input  logic        clear_tspin,
    output logic        bar_valid,
    input  logic        bar_ready,
    output logic [9:0]  bar_mask,
    output logic [5:0]  pending_lines,
    output logic        overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2((DEPTH + 1) * 32);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_e;

    state_e        state_q, state_d;
    logic [4:0]    cur_count_q, cur_count_d;
    logic [3:0]    cur_hole_q, cur_hole_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] pending_q, pending_d;
    logic          overflow_q, overflow_d;

    logic [2:0] lines_sat;
    logic [5:0] base, bonus, b2b_bonus, attack_sum, attack;
    logic [3:0] hole;
    logic       fifo_empty, fifo_full, has_attack, push, pop, handshake;
    logic       unused_rng;

    assign unused_rng = ^rng[31:4];

`ifdef GARBAGE_BACK_TO_BACK_EN
    logic b2b_q, b2b_d, qualify;

    // Only an actual line clear moves the flag; a qualifying clear keeps the chain alive.
    always_comb begin
        qualify   = (lines_sat != 3'd0) && ((lines_sat == 3'd4) || clear_tspin);
        b2b_d     = b2b_q;
        if (clear_valid && (lines_sat != 3'd0)) begin
            b2b_d = qualify;
        end
        b2b_bonus = {5'd0, b2b_q && qualify};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            b2b_q <= 1'b0;
        end else begin
            b2b_q <= b2b_d;
        end
    end
`else
    always_comb begin
        b2b_bonus = '0;
    end
`endif

    always_comb begin
        lines_sat = (clear_lines > 3'd4) ? 3'd4 : clear_lines;
        if (clear_tspin) begin
            base = {2'b00, lines_sat, 1'b0};
        end else begin
            case (lines_sat)
                3'd2:    base = 6'd1;
                3'd3:    base = 6'd2;
                3'd4:    base = 6'd4;
                default: base = 6'd0;
            endcase
        end
        if (clear_combo >= 8'd6)      bonus = 6'd3;
        else if (clear_combo >= 8'd4) bonus = 6'd2;
        else if (clear_combo >= 8'd2) bonus = 6'd1;
        else                          bonus = 6'd0;
        attack_sum = base + bonus + b2b_bonus;
        attack     = (attack_sum > 6'(MAX_ATTACK)) ? 6'(MAX_ATTACK) : attack_sum;
        hole       = rng[3:0] % 4'd10;
    end

    always_comb begin
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == CW'(DEPTH));
        state_d     = state_q;
        cur_count_d = cur_count_q;
        cur_hole_d  = cur_hole_q;
        gap_cnt_d   = gap_cnt_q;
        pop         = 1'b0;
        handshake   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                pop         = 1'b1;
                cur_count_d = mem_q[rd_ptr_q][8:4];
                cur_hole_d  = mem_q[rd_ptr_q][3:0];
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (bar_ready) begin
                    handshake   = 1'b1;
                    cur_count_d = cur_count_q - 5'd1;
                    if (cur_count_q == 5'd1) begin
                        state_d = fifo_empty ? S_IDLE : S_LOAD;
                    end else if (GAP_CYCLES > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = GW'(GAP_CYCLES - 1);
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) state_d = S_SEND;
                else                 gap_cnt_d = gap_cnt_q - GW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // A pop on the same edge frees the slot, so a full FIFO can still accept.
        has_attack = clear_valid && (attack != '0);
        push       = has_attack && (!fifo_full || pop);
        overflow_d = has_attack && fifo_full && !pop;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        pending_d  = pending_q + (push ? TW'(attack) : '0) - TW'(handshake);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_count_q <= '0;
            cur_hole_q  <= '0;
            gap_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_count_q <= cur_count_d;
            cur_hole_q  <= cur_hole_d;
            gap_cnt_q   <= gap_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {attack[4:0], hole};
        end
    end

    always_comb begin
        bar_valid     = (state_q == S_SEND);
        bar_mask      = bar_valid ? (10'd1 << cur_hole_q) : '0;
        pending_lines = (pending_q > TW'(63)) ? 6'd63 : pending_q[5:0];
        overflow      = overflow_q;
    end
endmodule

// File: tb/tb_garbage_sender.sv
// Self-checking bench for garbage_sender: directed vector table, corner-case sequences and a randomized model run.
module tb_garbage_sender;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rng;
    logic        clear_valid;
    logic [2:0]  clear_lines;
    logic [7:0]  clear_combo;
    logic        clear_tspin;
    logic        bar_ready;
    logic        bar_valid, overflow;
    logic [9:0]  bar_mask;
    logic [5:0]  pending_lines;
    logic        g_bar_valid, g_overflow;
    logic [9:0]  g_bar_mask;
    logic [5:0]  g_pending_lines;

    always #5 clk = ~clk;

    garbage_sender #(.DEPTH(DEPTH), .GAP_CYCLES(0), .MAX_ATTACK(12)) dut (
        .clk(clk), .reset(reset), .rng(rng), .clear_valid(clear_valid),
        .clear_lines(clear_lines), .clear_combo(clear_combo), .clear_tspin(clear_tspin),
        .bar_valid(bar_valid), .bar_ready(bar_ready), .bar_mask(bar_mask),
        .pending_lines(pending_lines), .overflow(overflow)
    );

    garbage_sender #(.DEPTH(DEPTH), .GAP_CYCLES(2), .MAX_ATTACK(8)) dut_gap (
        .clk(clk), .reset(reset), .rng(rng), .clear_valid(clear_valid),
        .clear_lines(clear_lines), .clear_combo(clear_combo), .clear_tspin(clear_tspin),
        .bar_valid(g_bar_valid), .bar_ready(bar_ready), .bar_mask(g_bar_mask),
        .pending_lines(g_pending_lines), .overflow(g_overflow)
    );

    int checks = 0;
    int failures = 0;

    typedef struct { int lines; int combo; bit tspin; int nib; int exp_att; int exp_hole; } vec_t;
    typedef struct { int cnt; int hole; } ev_t;

    vec_t vecs[10];
    ev_t  q[$];
    bit   m_b2b;
    int   stall, max_stall;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_attack(input int l, input int c, input bit t, input bit b2b, input int max_att);
        int base_tab[5] = '{0, 0, 1, 2, 4};
        int ls, a;
        bit b2b_en;
`ifdef GARBAGE_BACK_TO_BACK_EN
        b2b_en = 1'b1;
`else
        b2b_en = 1'b0;
`endif
        ls = (l > 4) ? 4 : l;
        a  = t ? 2 * ls : base_tab[ls];
        a += (c >= 6) ? 3 : c / 2;
        a += (b2b_en && b2b && ls > 0 && (ls == 4 || t)) ? 1 : 0;
        return (a > max_att) ? max_att : a;
    endfunction

    function automatic int model_pending();
        int s = 0;
        foreach (q[i]) s += q[i].cnt;
        return (s > 63) ? 63 : s;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        clear_valid = 1'b0;
        bar_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One event driven for exactly one cycle; returns at the negedge after it was sampled.
    task automatic pulse(input int l, input int c, input bit t, input int nib);
        clear_lines = 3'(l);
        clear_combo = 8'(c);
        clear_tspin = t;
        rng = ($urandom() & 32'hFFFF_FFF0) | 32'(nib);
        clear_valid = 1'b1;
        @(negedge clk);
        clear_valid = 1'b0;
    endtask

    task automatic model_cycle(input bit cv, input int l, input int c, input bit t, input int nib, input bit rdy);
        int att;
        bit hs;
        att = model_attack(l, c, t, m_b2b, 12);
        clear_valid = cv;
        clear_lines = 3'(l);
        clear_combo = 8'(c);
        clear_tspin = t;
        rng = ($urandom() & 32'hFFFF_FFF0) | 32'(nib);
        bar_ready = rdy;
        if (bar_valid) begin
            if (q.size() == 0) check("rand_spurious_valid", 1, 0);
            else check("rand_mask", bar_mask, 1 << q[0].hole);
        end else begin
            check("rand_idle_mask", bar_mask, 0);
        end
        hs = bar_valid && rdy;
        if (q.size() > 0 && !bar_valid) stall++;
        else stall = 0;
        if (stall > max_stall) max_stall = stall;
        @(posedge clk);
        if (hs && q.size() > 0) begin
            q[0].cnt--;
            if (q[0].cnt == 0) void'(q.pop_front());
        end
        if (cv && att > 0) q.push_back('{att, nib % 10});
        if (cv && l > 0) m_b2b = (l >= 4) || t;
        @(negedge clk);
        clear_valid = 1'b0;
        check("rand_pending", pending_lines, model_pending());
        check("rand_overflow", overflow, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_xfer, first, idx, l, c, nib;
        bit t, cv;
        int gap_pat[8] = '{1, 0, 0, 1, 0, 0, 1, 0};
        int ovf_holes[14] = '{3, 3, 3, 3, 2, 2, 4, 4, 5, 5, 8, 8, 8, 8};

        reset = 1'b1; rng = '0; clear_valid = 1'b0; clear_lines = '0;
        clear_combo = '0; clear_tspin = 1'b0; bar_ready = 1'b0;

        do_reset();
        check("reset_valid", bar_valid, 0);
        check("reset_mask", bar_mask, 0);
        check("reset_pending", pending_lines, 0);
        check("reset_overflow", overflow, 0);
        check("reset_gap_valid", g_bar_valid, 0);

        vecs[0] = '{4, 0,   1'b0, 7,  4,  7};
        vecs[1] = '{1, 0,   1'b0, 4,  0,  4};
        vecs[2] = '{2, 4,   1'b0, 1,  3,  1};
        vecs[3] = '{3, 9,   1'b1, 0,  9,  0};
        vecs[4] = '{3, 2,   1'b0, 12, 3,  2};
        vecs[5] = '{7, 0,   1'b0, 15, 4,  5};
        vecs[6] = '{2, 6,   1'b1, 9,  7,  9};
        vecs[7] = '{4, 255, 1'b1, 10, 11, 0};
        vecs[8] = '{0, 0,   1'b1, 6,  0,  6};
        vecs[9] = '{1, 3,   1'b0, 3,  1,  3};

        for (int i = 0; i < 10; i++) begin
            do_reset();
            bar_ready = 1'b1;
            pulse(vecs[i].lines, vecs[i].combo, vecs[i].tspin, vecs[i].nib);
            check("vec_pending", pending_lines, vecs[i].exp_att);
            check("vec_overflow", overflow, 0);
            n_xfer = 0;
            first = -1;
            for (int cyc = 1; cyc < 25; cyc++) begin
                if (bar_valid) begin
                    if (first < 0) first = cyc;
                    n_xfer++;
                    check("vec_mask", bar_mask, 1 << vecs[i].exp_hole);
                end
                @(negedge clk);
            end
            check("vec_xfers", n_xfer, vecs[i].exp_att);
            if (vecs[i].exp_att > 0) check("vec_latency", first, 3);
            check("vec_pending_end", pending_lines, 0);
        end

        // GAP_CYCLES=2 instance: 3 lines spaced by two idle cycles
        do_reset();
        bar_ready = 1'b1;
        pulse(3, 2, 1'b0, 6);
        check("gap_pending", g_pending_lines, 3);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            check("gap_valid", g_bar_valid, gap_pat[k]);
            if (gap_pat[k] == 1) check("gap_mask", g_bar_mask, 1 << 6);
            @(negedge clk);
        end
        check("gap_pending_end", g_pending_lines, 0);

        // Saturation: 8+3=11 is below 12 on dut, clipped to 8 on dut_gap
        do_reset();
        pulse(4, 9, 1'b1, 5);
        check("sat_pending_12", pending_lines, 11);
        check("sat_pending_8", g_pending_lines, 8);

`ifdef GARBAGE_BACK_TO_BACK_EN
        do_reset();
        pulse(4, 0, 1'b0, 1);
        pulse(3, 9, 1'b1, 2);
        check("b2b_pending", pending_lines, 14);
`endif

        // Overflow, then push and pop on the same edge while full
        do_reset();
        pulse(2, 0, 1'b0, 1);
        @(negedge clk);
        @(negedge clk);
        check("ovf_head_valid", bar_valid, 1);
        check("ovf_head_mask", bar_mask, 1 << 1);
        pulse(4, 0, 1'b0, 3);
        pulse(3, 0, 1'b0, 2);
        pulse(1, 0, 1'b1, 4);
        pulse(2, 2, 1'b0, 5);
        check("ovf_full_no_pulse", overflow, 0);
        check("ovf_full_pending", pending_lines, 11);
        pulse(4, 0, 1'b0, 6);
        check("ovf_pulse", overflow, 1);
        check("ovf_pending_unchanged", pending_lines, 11);
        @(negedge clk);
        check("ovf_pulse_end", overflow, 0);
        check("ovf_mask_held", bar_mask, 1 << 1);
        bar_ready = 1'b1;
        @(negedge clk);
        check("ovf_after_hs_pending", pending_lines, 10);
        pulse(3, 4, 1'b0, 8);
        check("ovf_pushpop_no_pulse", overflow, 0);
        check("ovf_pushpop_pending", pending_lines, 14);
        idx = 0;
        for (int cyc = 0; cyc < 60 && idx < 14; cyc++) begin
            if (bar_valid) begin
                check("ovf_drain_mask", bar_mask, 1 << ovf_holes[idx]);
                idx++;
            end
            @(negedge clk);
        end
        check("ovf_drain_count", idx, 14);
        check("ovf_drain_pending", pending_lines, 0);

        // Reset in the middle of SEND discards everything
        do_reset();
        pulse(4, 0, 1'b0, 7);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_valid_before", bar_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", bar_valid, 0);
        check("rst_mid_mask", bar_mask, 0);
        check("rst_mid_pending", pending_lines, 0);
        reset = 1'b0;
        bar_ready = 1'b1;
        pulse(2, 0, 1'b0, 2);
        n_xfer = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (bar_valid) begin
                n_xfer++;
                check("rst_new_mask", bar_mask, 1 << 2);
            end
            @(negedge clk);
        end
        check("rst_new_xfers", n_xfer, 1);

        // Randomized run against the queue model, never exceeding DEPTH outstanding events
        do_reset();
        q.delete();
        m_b2b = 1'b0;
        stall = 0;
        max_stall = 0;
        for (int n = 0; n < 3000; n++) begin
            l   = $urandom_range(0, 7);
            c   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
            t   = ($urandom_range(0, 3) == 0) && (l != 0);
            nib = $urandom_range(0, 15);
            cv  = ($urandom_range(0, 2) == 0);
            if (model_attack(l, c, t, m_b2b, 12) > 0 && q.size() >= DEPTH) cv = 1'b0;
            model_cycle(cv, l, c, t, nib, 1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 200 && q.size() > 0; n++) begin
            model_cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
        end
        check("rand_drain_empty", q.size(), 0);
        check("rand_drain_pending", pending_lines, 0);
        check("rand_max_stall_ok", (max_stall <= 2) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
